// File: rtl/flow_counter_rmw_ctrl.sv
// flow_counter_rmw_ctrl: per-flow counter table controller. Port 1 zeroes the
// table during INIT and carries update reads during RUN. Port 2 carries update
// writebacks and host reads/clears. A single-entry writeback register covers
// the one-cycle read-after-write hazard between the two ports.
module flow_counter_rmw_ctrl #(
  parameter int ADDR_BITS   = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int DELTA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [ADDR_BITS-1:0]   upd_addr,
  input  logic [DELTA_WIDTH-1:0] upd_delta,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  input  logic                   rd_clear,
  output logic                   rd_resp_valid,
  output logic [CNT_WIDTH-1:0]   rd_resp_data,
  output logic                   init_busy,
  output logic                   bram_en1,
  output logic                   bram_we1,
  output logic [ADDR_BITS-1:0]   bram_addr1,
  output logic [CNT_WIDTH-1:0]   bram_din1,
  input  logic [CNT_WIDTH-1:0]   bram_dout1,
  output logic                   bram_en2,
  output logic                   bram_we2,
  output logic [ADDR_BITS-1:0]   bram_addr2,
  output logic [CNT_WIDTH-1:0]   bram_din2,
  input  logic [CNT_WIDTH-1:0]   bram_dout2
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = {ADDR_BITS{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [0:0]             state_q, state_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [ADDR_BITS-1:0]   s1_addr_q, s1_addr_d;
  logic [DELTA_WIDTH-1:0] s1_delta_q, s1_delta_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [ADDR_BITS-1:0]   wb_addr_q, wb_addr_d;
  logic [CNT_WIDTH-1:0]   wb_data_q, wb_data_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [CNT_WIDTH-1:0]   resp_data_q, resp_data_d;

  logic                   run, upd_fire, rd_fire, wb_go;
  logic [CNT_WIDTH-1:0]   old_val, upd_result;
  logic [CNT_WIDTH:0]     sum;

  // Handshakes: a pending writeback owns port 2, so a host read waits for a
  // bubble, and an update yields one cycle to let that bubble happen.
  always_comb begin
    run       = !rst && (state_q == ST_RUN);
    rd_ready  = run && !s1_valid_q;
    upd_ready = run && !(rd_valid && s1_valid_q);
    init_busy = rst || (state_q == ST_INIT);
    upd_fire  = upd_valid && upd_ready;
    rd_fire   = rd_valid && rd_ready;
    wb_go     = !rst && s1_valid_q;
  end

  // Stage 1 accumulate: forward last cycle's port-2 write, then saturate.
  always_comb begin
    old_val    = (wb_valid_q && (wb_addr_q == s1_addr_q)) ? wb_data_q : bram_dout1;
    sum        = {1'b0, old_val} +
                 {{(CNT_WIDTH + 1 - DELTA_WIDTH){1'b0}}, s1_delta_q};
    upd_result = sum[CNT_WIDTH] ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  // Port 1: zero-fill during INIT, update read during RUN.
  always_comb begin
    bram_en1   = 1'b0;
    bram_we1   = 1'b0;
    bram_addr1 = '0;
    bram_din1  = '0;
    if (!rst && state_q == ST_INIT) begin
      bram_en1   = 1'b1;
      bram_we1   = 1'b1;
      bram_addr1 = idx_q;
    end else if (upd_fire) begin
      bram_en1   = 1'b1;
      bram_addr1 = upd_addr;
    end
  end

  // Port 2: writeback has priority; host read/clear only in a free cycle.
  always_comb begin
    bram_en2   = 1'b0;
    bram_we2   = 1'b0;
    bram_addr2 = '0;
    bram_din2  = '0;
    if (wb_go) begin
      bram_en2   = 1'b1;
      bram_we2   = 1'b1;
      bram_addr2 = s1_addr_q;
      bram_din2  = upd_result;
    end else if (rd_fire) begin
      bram_en2   = 1'b1;
      bram_we2   = rd_clear;
      bram_addr2 = rd_addr;
    end
  end

  // Response: live BRAM data on the pulse cycle, held copy afterwards.
  always_comb begin
    rd_resp_valid = resp_valid_q;
    rd_resp_data  = resp_valid_q ? bram_dout2 : resp_data_q;
  end

  // Next-state: FSM, init index, stage-1 pipeline, writeback register.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) state_d = ST_RUN;
    end
    s1_valid_d   = upd_fire;
    s1_addr_d    = upd_fire ? upd_addr  : s1_addr_q;
    s1_delta_d   = upd_fire ? upd_delta : s1_delta_q;
    wb_valid_d   = bram_en2 && bram_we2;
    wb_addr_d    = bram_addr2;
    wb_data_d    = bram_din2;
    resp_valid_d = rd_fire;
    resp_data_d  = rd_resp_data;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_delta_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_delta_q   <= s1_delta_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_flow_counter_rmw_ctrl.sv
// Bench for flow_counter_rmw_ctrl with a read-first dual-port BRAM model,
// a reference counter table, and a response scoreboard.
module tb_flow_counter_rmw_ctrl;
  localparam int AB = 4;
  localparam int CW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst;
  logic upd_valid, upd_ready, rd_valid, rd_ready, rd_clear;
  logic [AB-1:0] upd_addr, rd_addr;
  logic [DW-1:0] upd_delta;
  logic rd_resp_valid, init_busy;
  logic [CW-1:0] rd_resp_data;
  logic bram_en1, bram_we1, bram_en2, bram_we2;
  logic [AB-1:0] bram_addr1, bram_addr2;
  logic [CW-1:0] bram_din1, bram_dout1, bram_din2, bram_dout2;

  always #5 clk = ~clk;

  flow_counter_rmw_ctrl #(.ADDR_BITS(AB), .CNT_WIDTH(CW), .DELTA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_delta(upd_delta),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_clear(rd_clear),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .init_busy(init_busy),
    .bram_en1(bram_en1), .bram_we1(bram_we1), .bram_addr1(bram_addr1),
    .bram_din1(bram_din1), .bram_dout1(bram_dout1),
    .bram_en2(bram_en2), .bram_we2(bram_we2), .bram_addr2(bram_addr2),
    .bram_din2(bram_din2), .bram_dout2(bram_dout2)
  );

  // Read-first true dual-port BRAM.
  logic [CW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_en1) begin
      bram_dout1 <= mem[bram_addr1];
      if (bram_we1) mem[bram_addr1] <= bram_din1;
    end
    if (bram_en2) begin
      bram_dout2 <= mem[bram_addr2];
      if (bram_we2) mem[bram_addr2] <= bram_din2;
    end
  end

  int vec = 0;
  int errs = 0;
  logic [CW-1:0] model [DEPTH];
  logic [CW-1:0] exp_q [$];
  logic ug_last, rg_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive after negedge, account handshakes in the model, clock.
  task automatic step(input logic uv, input logic [AB-1:0] ua, input logic [DW-1:0] ud,
                      input logic rv, input logic [AB-1:0] ra, input logic rc);
    logic [CW:0] s;
    @(negedge clk);
    upd_valid = uv; upd_addr = ua; upd_delta = ud;
    rd_valid = rv; rd_addr = ra; rd_clear = rc;
    #1;
    ug_last = upd_valid && upd_ready;
    rg_last = rd_valid && rd_ready;
    if (rg_last) begin
      exp_q.push_back(model[ra]);
      if (rc) model[ra] = '0;
    end
    if (ug_last) begin
      s = {1'b0, model[ua]} + {1'b0, ud};
      model[ua] = s[CW] ? {CW{1'b1}} : s[CW-1:0];
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AB-1:0] a);
    step(1'b0, '0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic upd(input logic [AB-1:0] a, input logic [DW-1:0] d);
    step(1'b1, a, d, 1'b0, '0, 1'b0);
  endtask

  // Release reset and count INIT cycles (bounded).
  task automatic do_init();
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    #1;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("init_cycles", n, DEPTH);
    chk("upd_ready_after_init", upd_ready, 1);
    chk("rd_ready_after_init", rd_ready, 1);
  endtask

  // Scoreboard: pop one expected value per response pulse.
  always @(negedge clk) begin
    if (!rst && rd_resp_valid) begin
      chk("resp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("rd_resp_data", rd_resp_data, exp_q.pop_front());
    end
  end

  initial begin
    int n, lows;
    rst = 1'b1;
    upd_valid = 0; upd_addr = '0; upd_delta = '0;
    rd_valid = 0; rd_addr = '0; rd_clear = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_resp_valid", rd_resp_valid, 0);
    chk("rst_resp_data", rd_resp_data, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_bram_en", {bram_en1, bram_we1, bram_en2, bram_we2}, 0);

    do_init();
    for (int a = 0; a < DEPTH; a++) rd(a[AB-1:0]);
    idle(2);

    // Single update, read at t+2.
    upd(3, 5);
    idle(1);
    rd(3);
    idle(2);

    // Back-to-back updates to one address exercise forwarding.
    upd(7, 1); upd(7, 2); upd(7, 3); upd(7, 4);
    idle(1);
    rd(7);
    idle(2);

    // Clear racing an update to the same address.
    upd(2, 100);
    idle(1);
    step(1'b1, 2, 9, 1'b1, 2, 1'b1);
    chk("race_upd_grant", ug_last, 1);
    chk("race_rd_grant", rg_last, 1);
    idle(1);
    rd(2);
    idle(2);

    // Saturation at 2**CW-1.
    upd(1, 250); upd(1, 10);
    idle(1);
    rd(1);
    upd(1, 1);
    idle(1);
    rd(1);
    idle(2);

    // Arbitration under continuous updates with a held host read.
    upd(5, 1); upd(5, 1);
    n = 0; lows = 0;
    do begin
      step(1'b1, 5, 1, 1'b1, 5, 1'b0);
      n++;
      if (!ug_last) lows++;
    end while (!rg_last && n < 10);
    chk("rd_grant_cycles", n, 2);
    chk("upd_stall_cycles", lows, 1);
    for (int i = 0; i < 3; i++) begin
      upd(5, 1);
      chk("upd_full_rate", ug_last, 1);
    end

    // Reset mid-stream with an update in flight.
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clk);
    chk("midrst_resp_valid", rd_resp_valid, 0);
    chk("midrst_init_busy", init_busy, 1);
    do_init();
    for (int a = 0; a < DEPTH; a++) rd(a[AB-1:0]);
    idle(3);
    chk("pending_responses", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
